// File: rtl/arp_ctrl.sv
// ARP transaction controller: resolves DES_IP with timeout/retry, answers
// incoming ARP requests, arbitrates the single ARP transmitter and caches
// the resolved peer MAC for the UDP layer.
module arp_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 125_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [31:0] DES_IP         = {8'd192, 8'd168, 8'd0, 8'd3},
    parameter logic        STARTUP_REQ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        gmii_tx_done,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic        peer_valid,
    output logic [47:0] peer_mac,
    output logic        resolve_fail,
    output logic        busy,
    output logic [2:0]  state
);

    localparam logic [2:0] IDLE           = 3'd0;
    localparam logic [2:0] SEND_REQ       = 3'd1;
    localparam logic [2:0] WAIT_REQ_DONE  = 3'd2;
    localparam logic [2:0] WAIT_REPLY     = 3'd3;
    localparam logic [2:0] SEND_RPLY      = 3'd4;
    localparam logic [2:0] WAIT_RPLY_DONE = 3'd5;
    localparam logic [2:0] FAIL           = 3'd6;

    localparam int unsigned TMR_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    logic [2:0]         state_q, state_d;
    logic               req_pend_q, req_pend_d;
    logic               rply_pend_q, rply_pend_d;
    logic               ret_wait_q, ret_wait_d;
    logic [47:0]        rply_mac_q, rply_mac_d;
    logic [31:0]        rply_ip_q, rply_ip_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               arp_tx_en_q, arp_tx_en_d;
    logic               arp_tx_type_q, arp_tx_type_d;
    logic [47:0]        des_mac_q, des_mac_d;
    logic [31:0]        des_ip_q, des_ip_d;
    logic               peer_valid_q, peer_valid_d;
    logic [47:0]        peer_mac_q, peer_mac_d;
    logic               resolve_fail_q, resolve_fail_d;
    logic               busy_q, busy_d;

    logic rx_req;
    logic rx_match;

    assign rx_req   = arp_rx_done && !arp_rx_type;
    assign rx_match = arp_rx_done && arp_rx_type && (src_ip == DES_IP);

    // Next-state, pending-flag, timer and registered-output computation
    always_comb begin
        state_d        = state_q;
        req_pend_d     = req_pend_q;
        rply_pend_d    = rply_pend_q;
        ret_wait_d     = ret_wait_q;
        rply_mac_d     = rply_mac_q;
        rply_ip_d      = rply_ip_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        arp_tx_type_d  = arp_tx_type_q;
        des_mac_d      = des_mac_q;
        des_ip_d       = des_ip_q;
        peer_valid_d   = peer_valid_q;
        peer_mac_d     = peer_mac_q;

        case (state_q)
            IDLE: begin
                if (rply_pend_q) begin
                    state_d     = SEND_RPLY;
                    rply_pend_d = 1'b0;
                    ret_wait_d  = 1'b0;
                end else if (req_pend_q) begin
                    state_d    = SEND_REQ;
                    req_pend_d = 1'b0;
                    retry_d    = '0;
                end
            end
            SEND_REQ: state_d = WAIT_REQ_DONE;
            WAIT_REQ_DONE: begin
                if (gmii_tx_done) begin
                    state_d = WAIT_REPLY;
                    timer_d = '0;
                end
            end
            WAIT_REPLY: begin
                if (rx_match) begin
                    state_d = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    timer_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = SEND_REQ;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (rply_pend_q) begin
                    // Timer is frozen (not incremented) across the reply detour.
                    state_d     = SEND_RPLY;
                    rply_pend_d = 1'b0;
                    ret_wait_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            SEND_RPLY: state_d = WAIT_RPLY_DONE;
            WAIT_RPLY_DONE: begin
                if (gmii_tx_done) begin
                    if (ret_wait_q) begin
                        state_d    = WAIT_REPLY;
                        ret_wait_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FAIL: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The pending reply is consumed when its SEND_RPLY is entered, so a
        // request arriving during transmission stays queued; new arrivals win
        // over a same-cycle clear.
        if (start) begin
            req_pend_d = 1'b1;
        end
        if (rx_req) begin
            rply_pend_d = 1'b1;
            rply_mac_d  = src_mac;
            rply_ip_d   = src_ip;
        end
        if (rx_match) begin
            peer_mac_d   = src_mac;
            peer_valid_d = 1'b1;
        end

        arp_tx_en_d = (state_d == SEND_REQ) || (state_d == SEND_RPLY);
        if (state_d == SEND_REQ) begin
            arp_tx_type_d = 1'b0;
            des_mac_d     = '1;
            des_ip_d      = DES_IP;
        end else if (state_d == SEND_RPLY) begin
            arp_tx_type_d = 1'b1;
            des_mac_d     = rply_mac_q;
            des_ip_d      = rply_ip_q;
        end
        resolve_fail_d = (state_d == FAIL);
        busy_d         = (state_d != IDLE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            req_pend_q     <= STARTUP_REQ;
            rply_pend_q    <= 1'b0;
            ret_wait_q     <= 1'b0;
            rply_mac_q     <= '0;
            rply_ip_q      <= '0;
            timer_q        <= '0;
            retry_q        <= '0;
            arp_tx_en_q    <= 1'b0;
            arp_tx_type_q  <= 1'b0;
            des_mac_q      <= '1;
            des_ip_q       <= DES_IP;
            peer_valid_q   <= 1'b0;
            peer_mac_q     <= '0;
            resolve_fail_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_pend_q     <= req_pend_d;
            rply_pend_q    <= rply_pend_d;
            ret_wait_q     <= ret_wait_d;
            rply_mac_q     <= rply_mac_d;
            rply_ip_q      <= rply_ip_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            arp_tx_en_q    <= arp_tx_en_d;
            arp_tx_type_q  <= arp_tx_type_d;
            des_mac_q      <= des_mac_d;
            des_ip_q       <= des_ip_d;
            peer_valid_q   <= peer_valid_d;
            peer_mac_q     <= peer_mac_d;
            resolve_fail_q <= resolve_fail_d;
            busy_q         <= busy_d;
        end
    end

    assign arp_tx_en    = arp_tx_en_q;
    assign arp_tx_type  = arp_tx_type_q;
    assign des_mac      = des_mac_q;
    assign des_ip       = des_ip_q;
    assign peer_valid   = peer_valid_q;
    assign peer_mac     = peer_mac_q;
    assign resolve_fail = resolve_fail_q;
    assign busy         = busy_q;
    assign state        = state_q;

endmodule

// File: tb/tb_arp_ctrl.sv
// Self-checking bench for arp_ctrl: transmitted frames are checked against a
// scoreboard of expected frames; timing and status are checked inline.
module tb_arp_ctrl;

    localparam logic [31:0] DIP = {8'd192, 8'd168, 8'd0, 8'd3};

    typedef struct packed {
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        arp_rx_done = 1'b0;
    logic        arp_rx_type = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0;
    logic        gmii_tx_done = 1'b0;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        peer_valid;
    logic [47:0] peer_mac;
    logic        resolve_fail;
    logic        busy;
    logic [2:0]  state;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned tx_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned n;
    frame_t      sb[$];

    arp_ctrl #(
        .TIMEOUT_CYCLES(100),
        .MAX_RETRY(3),
        .DES_IP(DIP),
        .STARTUP_REQ(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .src_mac(src_mac), .src_ip(src_ip), .gmii_tx_done(gmii_tx_done),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .des_mac(des_mac), .des_ip(des_ip),
        .peer_valid(peer_valid), .peer_mac(peer_mac),
        .resolve_fail(resolve_fail), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        frame_t f;
        f.typ = typ;
        f.mac = mac;
        f.ip  = ip;
        sb.push_back(f);
    endtask

    task automatic wait_state(input logic [2:0] s, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (state !== s && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(state), 64'(s));
    endtask

    // Counts cycles spent in WAIT_REPLY from the current negedge.
    task automatic count_wait(output int unsigned cnt);
        cnt = 0;
        while (state === 3'd3 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic pulse_done();
        gmii_tx_done = 1'b1;
        @(negedge clk);
        gmii_tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1;
        arp_rx_type = typ;
        src_mac     = mac;
        src_ip      = ip;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_en"}, 64'(arp_tx_en), 64'd0);
        chk({tag, "_tx_type"}, 64'(arp_tx_type), 64'd0);
        chk({tag, "_des_mac"}, 64'(des_mac), 64'hFFFF_FFFF_FFFF);
        chk({tag, "_des_ip"}, 64'(des_ip), 64'(DIP));
        chk({tag, "_peer_valid"}, 64'(peer_valid), 64'd0);
        chk({tag, "_peer_mac"}, 64'(peer_mac), 64'd0);
        chk({tag, "_fail"}, 64'(resolve_fail), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_state"}, 64'(state), 64'd0);
    endtask

    // Transmit monitor: every arp_tx_en cycle must match the oldest expected frame
    always @(negedge clk) begin
        if (rst && arp_tx_en) begin
            tx_cnt++;
            if (sb.size() == 0) begin
                chk("tx_unexpected", 64'd1, 64'd0);
            end else begin
                frame_t e;
                e = sb.pop_front();
                chk("tx_type", 64'(arp_tx_type), 64'(e.typ));
                chk("tx_des_mac", 64'(des_mac), 64'(e.mac));
                chk("tx_des_ip", 64'(des_ip), 64'(e.ip));
            end
        end
        if (rst && resolve_fail) fail_cnt++;
    end

    initial begin
        #2 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst0");

        // Startup resolve
        push_frame(1'b0, 48'hFFFF_FFFF_FFFF, DIP);
        rst = 1'b1;
        wait_state(3'd1, 10, "st_send_req");
        wait_state(3'd2, 10, "st_wait_done");
        pulse_done();
        chk("st_wait_reply", 64'(state), 64'd3);
        repeat (20) @(negedge clk);
        pulse_rx(1'b1, 48'h0A1B2C3D4E5F, DIP);
        chk("st_peer_valid", 64'(peer_valid), 64'd1);
        chk("st_peer_mac", 64'(peer_mac), 64'h0A1B2C3D4E5F);
        chk("st_idle", 64'(state), 64'd0);
        chk("st_busy", 64'(busy), 64'd0);

        // gmii_tx_done while idle is ignored
        pulse_done();
        chk("idle_done_ignored", 64'(state), 64'd0);

        // Incoming request in IDLE
        push_frame(1'b1, 48'h112233445566, {8'd192, 8'd168, 8'd0, 8'd9});
        pulse_rx(1'b0, 48'h112233445566, {8'd192, 8'd168, 8'd0, 8'd9});
        wait_state(3'd4, 10, "rq_send_rply");
        wait_state(3'd5, 10, "rq_wait_done");
        pulse_done();
        chk("rq_idle", 64'(state), 64'd0);

        // Simultaneous start and incoming request: reply first
        push_frame(1'b1, 48'hA0A1A2A3A4A5, {8'd10, 8'd0, 8'd0, 8'd7});
        push_frame(1'b0, 48'hFFFF_FFFF_FFFF, DIP);
        start       = 1'b1;
        arp_rx_done = 1'b1;
        arp_rx_type = 1'b0;
        src_mac     = 48'hA0A1A2A3A4A5;
        src_ip      = {8'd10, 8'd0, 8'd0, 8'd7};
        @(negedge clk);
        start       = 1'b0;
        arp_rx_done = 1'b0;
        wait_state(3'd4, 10, "sim_send_rply");
        wait_state(3'd5, 10, "sim_wait_rply");
        pulse_done();
        wait_state(3'd1, 10, "sim_send_req");
        wait_state(3'd2, 10, "sim_wait_req");
        pulse_done();
        chk("sim_wait_reply", 64'(state), 64'd3);

        // Request arriving at timer=40 during WAIT_REPLY
        repeat (39) @(negedge clk);
        push_frame(1'b1, 48'h665544332211, {8'd192, 8'd168, 8'd0, 8'd20});
        pulse_rx(1'b0, 48'h665544332211, {8'd192, 8'd168, 8'd0, 8'd20});
        wait_state(3'd4, 10, "t40_send_rply");
        wait_state(3'd5, 10, "t40_wait_rply");
        push_frame(1'b0, 48'hFFFF_FFFF_FFFF, DIP);
        pulse_done();
        chk("t40_resume", 64'(state), 64'd3);
        count_wait(n);
        chk("t40_remaining", 64'(n), 64'd60);
        chk("t40_retry_req", 64'(state), 64'd1);

        // Reset in the middle of WAIT_REPLY
        wait_state(3'd2, 10, "mr_wait_req");
        pulse_done();
        repeat (10) @(negedge clk);
        chk("mr_pre_state", 64'(state), 64'd3);
        rst = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (3) @(negedge clk);
        chk("mr_sb_empty", 64'(sb.size()), 64'd0);

        // No reply after release: startup request, 3 retries, then failure
        for (int i = 0; i < 4; i++) push_frame(1'b0, 48'hFFFF_FFFF_FFFF, DIP);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_state(3'd1, 300, "nr_send_req");
            wait_state(3'd2, 10, "nr_wait_done");
            pulse_done();
            count_wait(n);
            chk("nr_timeout_gap", 64'(n), 64'd100);
        end
        chk("nr_fail_state", 64'(state), 64'd6);
        chk("nr_fail_pulse", 64'(resolve_fail), 64'd1);
        chk("nr_peer_valid", 64'(peer_valid), 64'd0);
        @(negedge clk);
        chk("nr_idle", 64'(state), 64'd0);
        chk("nr_fail_low", 64'(resolve_fail), 64'd0);

        // Reply from a different IP is not a match; a gratuitous match still updates
        pulse_rx(1'b1, 48'h123456789ABC, {8'd192, 8'd168, 8'd0, 8'd4});
        chk("gr_nomatch_valid", 64'(peer_valid), 64'd0);
        pulse_rx(1'b1, 48'hCAFEBABE0001, DIP);
        chk("gr_valid", 64'(peer_valid), 64'd1);
        chk("gr_mac", 64'(peer_mac), 64'hCAFEBABE0001);
        chk("gr_idle", 64'(state), 64'd0);

        repeat (3) @(negedge clk);
        chk("end_sb_empty", 64'(sb.size()), 64'd0);
        chk("end_tx_count", 64'(tx_cnt), 64'd10);
        chk("end_fail_count", 64'(fail_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
